sram_fabric_req_ctrl: RTL



---
 rtl/sram_fabric_pkg.sv | 96 +++++++++
 rtl/sram_resp_fifo.sv | 48 ++++
 rtl/sram_fabric_req_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/sram_fabric_pkg.sv
// Shared types, width codes and address helpers for the fabric-side SRAM request path.
package sram_fabric_pkg;

  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ROW_W  = 9;
  localparam int unsigned UNIT_W = 2;
  localparam int unsigned OFF_W  = 3;
  localparam int unsigned CONF_W = 3;

  localparam logic [CONF_W-1:0] CONF_32 = 3'b101;
  localparam logic [CONF_W-1:0] CONF_16 = 3'b100;
  localparam logic [CONF_W-1:0] CONF_8  = 3'b011;
  localparam logic [CONF_W-1:0] CONF_4  = 3'b010;
  localparam logic [CONF_W-1:0] CONF_2  = 3'b001;
  localparam logic [CONF_W-1:0] CONF_1  = 3'b000;

  typedef struct packed {
    logic [ROW_W-1:0]  row;
    logic [UNIT_W-1:0] unit;
    logic [OFF_W-1:0]  offset;
    logic              err;
  } addr_fields_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              err;
  } resp_entry_t;

  typedef struct packed {
    logic act;
    logic track;
    logic err;
  } tag_t;

  function automatic logic [2:0] width_shift(input logic [CONF_W-1:0] conf);
    case (conf)
      CONF_32: return 3'd5;
      CONF_16: return 3'd4;
      CONF_8:  return 3'd3;
      CONF_4:  return 3'd2;
      CONF_2:  return 3'd1;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] width_mask(input logic [CONF_W-1:0] conf);
    logic [5:0] bits;
    bits = 6'(1) << width_shift(conf);
    if (bits == 6'd32) return '1;
    return (DATA_W'(1) << bits) - DATA_W'(1);
  endfunction

  // Flat address is {row, slot, unit}; upper bits beyond the row field must be zero.
  function automatic addr_fields_t decompose_addr(input logic [ADDR_W-1:0] lin,
                                                  input logic [CONF_W-1:0] conf);
    addr_fields_t f;
    f = '0;
    case (conf)
      CONF_32: begin
        f.row = lin[8:0];
        f.err = |lin[13:9];
      end
      CONF_16: begin
        f.row  = lin[9:1];
        f.unit = {1'b0, lin[0]};
        f.err  = |lin[13:10];
      end
      CONF_8: begin
        f.row  = lin[10:2];
        f.unit = lin[1:0];
        f.err  = |lin[13:11];
      end
      CONF_4: begin
        f.row    = lin[11:3];
        f.unit   = lin[1:0];
        f.offset = {lin[2], 2'b00};
        f.err    = |lin[13:12];
      end
      CONF_2: begin
        f.row    = lin[12:4];
        f.unit   = lin[1:0];
        f.offset = {lin[3:2], 1'b0};
        f.err    = lin[13];
      end
      CONF_1: begin
        f.row    = lin[13:5];
        f.unit   = lin[1:0];
        f.offset = lin[4:2];
      end
      default: f.err = 1'b1;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/sram_resp_fifo.sv
// Synchronous response FIFO; count feeds the upstream credit check.
module sram_resp_fifo
  import sram_fabric_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  resp_entry_t                  push_data,
  input  logic                         pop,
  output logic                         valid,
  output resp_entry_t                  head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  resp_entry_t      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;

  assign valid  = (count != '0);
  assign do_pop = pop & valid;
  assign head   = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      assert (!(push && !do_pop && count == CNT_W'(DEPTH)))
        else $error("sram_resp_fifo: push into full FIFO");
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/sram_fabric_req_ctrl.sv
// Fabric request controller: decomposes flat addresses, drives the SRAM interface
// registers and returns in-order responses under credit control.
module sram_fabric_req_ctrl
  import sram_fabric_pkg::*;
#(
  parameter int unsigned READ_LAT   = 2,
  parameter int unsigned RESP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CONF_W-1:0] cfg_conf,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic              busy,
  output logic              sram_csb,
  output logic              sram_web,
  output logic [ROW_W-1:0]  sram_addr,
  output logic [UNIT_W-1:0] sram_addr_2_4,
  output logic [OFF_W-1:0]  sram_addr_3_8,
  output logic [CONF_W-1:0] sram_conf,
  output logic [DATA_W-1:0] sram_d_fabric,
  input  logic [DATA_W-1:0] sram_d_out
);

  localparam int unsigned IF_W   = $clog2(RESP_DEPTH + READ_LAT + 2);
  localparam int unsigned FCNT_W = $clog2(RESP_DEPTH + 1);

  addr_fields_t       fields;
  logic               accept;
  tag_t               req_tag_q;
  tag_t               pipe_q [READ_LAT];
  tag_t               last;
  logic               push;
  logic               pop;
  resp_entry_t        push_entry;
  resp_entry_t        head;
  logic [FCNT_W-1:0]  fifo_count;
  logic [FCNT_W-1:0]  fifo_count_nxt;
  logic [IF_W-1:0]    inflight;
  logic               busy_nxt;

  assign fields = decompose_addr(req_addr, cfg_conf);
  assign accept = req_valid & req_ready;

  // Request register stage: csb/web pulse low for one cycle per good request.
  always_ff @(posedge clk) begin
    if (rst) begin
      sram_csb      <= 1'b1;
      sram_web      <= 1'b1;
      sram_addr     <= '0;
      sram_addr_2_4 <= '0;
      sram_addr_3_8 <= '0;
      sram_conf     <= '0;
      sram_d_fabric <= '0;
      req_tag_q     <= '0;
    end else begin
      sram_csb  <= !(accept && !fields.err);
      sram_web  <= !(accept && !fields.err && req_we);
      req_tag_q <= '{act: accept, track: accept && (!req_we || fields.err),
                     err: accept && fields.err};
      if (accept) begin
        sram_addr     <= fields.row;
        sram_addr_2_4 <= fields.unit;
        sram_addr_3_8 <= fields.offset;
        sram_conf     <= cfg_conf;
        sram_d_fabric <= req_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < READ_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= req_tag_q;
      for (int unsigned i = 1; i < READ_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign last            = pipe_q[READ_LAT-1];
  assign push            = last.act & last.track;
  assign push_entry.err  = last.err;
  assign push_entry.data = last.err ? '0 : (sram_d_out & width_mask(cfg_conf));
  assign pop             = resp_valid & resp_ready;

  sram_resp_fifo #(.DEPTH(RESP_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .valid     (resp_valid),
    .head      (head),
    .count     (fifo_count)
  );

  assign resp_data = head.data;
  assign resp_err  = head.err;

  // Credits count every response already owed, whether still in the pipe or queued.
  always_comb begin
    inflight = IF_W'(fifo_count) + IF_W'(req_tag_q.track);
    for (int unsigned i = 0; i < READ_LAT; i++) inflight = inflight + IF_W'(pipe_q[i].track);
  end

  assign req_ready = !rst && (inflight < IF_W'(RESP_DEPTH));

  always_comb begin
    fifo_count_nxt = fifo_count + FCNT_W'(push) - FCNT_W'(pop);
    busy_nxt       = accept | req_tag_q.act | (fifo_count_nxt != '0);
    for (int unsigned i = 0; i + 1 < READ_LAT; i++) busy_nxt = busy_nxt | pipe_q[i].act;
  end

  always_ff @(posedge clk) begin
    if (rst) busy <= 1'b0;
    else     busy <= busy_nxt;
  end

endmodule
